// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encodings
// and result-slot indices used by consumers of the eq/gt/lt triple.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int RES_EQ = 0;
  localparam int RES_GT = 1;
  localparam int RES_LT = 2;

endpackage

// File: rtl/comparator.sv
// 1-bit equality cell: eq is high when both input bits match.
module comparator (
  input  logic i0,
  input  logic i1,
  output logic eq
);

  assign eq = ~(i0 ^ i1);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: streams operand bits MSB first
// through one 1-bit equality cell and reports eq/gt/lt plus bits examined.
module serial_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter  int WIDTH      = 8,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles,
  output logic             busy
);

  // Handshake contract: a transfer happens on a rising edge where valid and
  // ready are both high; valid-side data must hold until that edge.

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    idx;
  logic             cmp_eq;
  logic             diff_now;
  logic             scan_exit;

  comparator u_cmp (
    .i0 (a_sh[WIDTH-1]),
    .i1 (b_sh[WIDTH-1]),
    .eq (cmp_eq)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = !in_ready;

  // A difference counts only once; gt/lt are sticky for the rest of the scan.
  assign diff_now  = (state == ST_SCAN) && !cmp_eq && !(gt || lt);
  assign scan_exit = (idx == '0) || (EARLY_EXIT && diff_now);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_SCAN;
      ST_SCAN: if (scan_exit) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            idx    <= CW'(WIDTH - 1);
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            cycles <= '0;
          end
        end
        ST_SCAN: begin
          cycles <= cycles + CW'(1);
          a_sh   <= {a_sh[WIDTH-2:0], 1'b0};
          b_sh   <= {b_sh[WIDTH-2:0], 1'b0};
          if (idx != '0) idx <= idx - CW'(1);
          if (diff_now) begin
            gt <= a_sh[WIDTH-1];
            lt <= ~a_sh[WIDTH-1];
          end
          // Equality is only known once the scan ends without any difference.
          if (scan_exit && !diff_now && !gt && !lt) eq <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl: one instance with early exit, one without,
// checked through per-instance expected-result queues.
module tb_serial_compare_ctrl;
  import serial_cmp_pkg::*;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid [2];
  logic [W-1:0] a_v [2];
  logic [W-1:0] b_v [2];
  logic        out_ready [2];
  wire  [1:0]  in_ready, out_valid, eq, gt, lt, busy;
  wire  [3:0]  cycles_0, cycles_1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc [2];
  logic [6:0] exp_q0[$];
  logic [6:0] exp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0]), .b(b_v[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .eq(eq[0]), .gt(gt[0]), .lt(lt[0]), .cycles(cycles_0), .busy(busy[0])
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1]), .b(b_v[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .eq(eq[1]), .gt(gt[1]), .lt(lt[1]), .cycles(cycles_1), .busy(busy[1])
  );

  function automatic logic [6:0] mk(int res, int k);
    logic [3:0] kk;
    kk = 4'(k);
    case (res)
      RES_EQ:  return {3'b100, kk};
      RES_GT:  return {3'b010, kk};
      default: return {3'b001, kk};
    endcase
  endfunction

  function automatic logic [6:0] result(int s);
    return (s == 0) ? {eq[0], gt[0], lt[0], cycles_0} : {eq[1], gt[1], lt[1], cycles_1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one operation; push the expected result when one should appear.
  task automatic send(int s, logic [W-1:0] av, logic [W-1:0] bv, bit expect_res, logic [6:0] e);
    int n;
    if (expect_res) begin
      if (s == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    end
    @(negedge clk);
    in_valid[s] = 1'b1;
    a_v[s] = av;
    b_v[s] = bv;
    n = 0;
    while (!in_ready[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    acc_cyc[s] = cyc + 1;
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
  endtask

  // Monitor: latency on out_valid rise, result compare on each output transfer.
  task automatic mon(int s);
    logic prev_ov;
    logic [6:0] e;
    int qs;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      qs = (s == 0) ? exp_q0.size() : exp_q1.size();
      if (out_valid[s] && !prev_ov) begin
        if (qs == 0) begin
          check($sformatf("unexpected_out_valid_%0d", s), 1, 0);
        end else begin
          e = (s == 0) ? exp_q0[0] : exp_q1[0];
          check($sformatf("latency_%0d", s), cyc - acc_cyc[s], {28'd0, e[3:0]});
        end
      end
      if (out_valid[s] && out_ready[s] && qs != 0) begin
        e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("result_%0d", s), {25'd0, result(s)}, {25'd0, e});
      end
      prev_ov = out_valid[s] && !out_ready[s];
      if (!rst_n) prev_ov = 1'b0;
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      out_ready[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("reset_result", {25'd0, result(0)}, 32'd0);
    check("reset_out_valid", {30'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", {30'd0, in_ready}, 32'd3);
    check("reset_busy", {30'd0, busy}, 32'd0);

    // Early-exit instance: equal, MSB differs, LSB-only differs, extra cases.
    send(0, 8'hA5, 8'hA5, 1, mk(RES_EQ, 8));
    send(0, 8'h80, 8'h7F, 1, mk(RES_GT, 1));
    send(0, 8'h12, 8'h13, 1, mk(RES_LT, 8));
    send(0, 8'h00, 8'hFF, 1, mk(RES_LT, 1));
    send(0, 8'hFF, 8'hFE, 1, mk(RES_GT, 8));
    send(0, 8'h3C, 8'h34, 1, mk(RES_GT, 5));
    // Full-scan instance: sticky difference, equal, LSB-only difference.
    send(1, 8'h80, 8'h00, 1, mk(RES_GT, 8));
    send(1, 8'h5A, 8'h5A, 1, mk(RES_EQ, 8));
    send(1, 8'h12, 8'h13, 1, mk(RES_LT, 8));
    send(1, 8'h00, 8'hFF, 1, mk(RES_LT, 8));

    // Backpressure: result must hold while out_ready is low.
    out_ready[0] = 1'b0;
    send(0, 8'h01, 8'h02, 1, mk(RES_LT, 7));
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("stall_wait_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", {31'd0, out_valid[0]}, 32'd1);
      check("stall_result", {25'd0, result(0)}, {25'd0, mk(RES_LT, 7)});
      check("stall_in_ready", {31'd0, in_ready[0]}, 32'd0);
      if (i == 1) begin
        in_valid[0] = 1'b1;
        a_v[0] = 8'hFF;
        b_v[0] = 8'h00;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("release_out_valid", {31'd0, out_valid[0]}, 32'd0);
    repeat (12) @(negedge clk);
    check("stall_operands_dropped", {31'd0, out_valid[0]}, 32'd0);

    // Reset during the third SCAN cycle discards the operation.
    send(0, 8'hFF, 8'hFF, 0, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("midreset_out_valid", {31'd0, out_valid[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_idle", {30'd0, out_valid[0], in_ready[0]}, 32'd1);
    send(0, 8'h03, 8'h05, 1, mk(RES_LT, 6));

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queues", n < 200 ? 32'd1 : 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
